// File: rtl/reg_port_responder.sv
// ============================================================================
// Module : reg_port_responder
// Brief  : Serialises valid/ready register-bank access requests, one at a time.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_port_responder #(
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter int DW       = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [4:0]    req_sel,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          bank_we,
    output logic [4:0]    bank_sel,
    output logic [DW-1:0] bank_in,
    input  logic [DW-1:0] bank_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [DW-1:0] rsp_data_q,  rsp_data_d;
    logic          bank_we_q,   bank_we_d;
    logic [4:0]    bank_sel_q,  bank_sel_d;
    logic [DW-1:0] bank_in_q,   bank_in_d;
    logic          wr_q,        wr_d;

    logic sel_oob;
    logic zero_hit;

    // One extra bit keeps the comparison meaningful when NREGS == 32.
    assign sel_oob  = ({1'b0, req_sel} >= 6'(NREGS));
    assign zero_hit = ZERO_REG && (req_sel == 5'd0);

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        bank_we_d   = bank_we_q;
        bank_sel_d  = bank_sel_q;
        bank_in_d   = bank_in_q;
        wr_d        = wr_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    wr_d        = req_write;
                    if (sel_oob || zero_hit) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = sel_oob;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = S_ACCESS;
                        bank_sel_d = req_sel;
                        if (req_write) begin
                            bank_we_d = 1'b1;
                            bank_in_d = req_data;
                        end
                    end
                end
            end
            S_ACCESS: begin
                bank_we_d = 1'b0;
                if (wr_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Bank read data is valid one cycle after the select was presented.
                rsp_data_d  = bank_out;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            bank_we_q   <= 1'b0;
            bank_sel_q  <= 5'd0;
            bank_in_q   <= '0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            bank_we_q   <= bank_we_d;
            bank_sel_q  <= bank_sel_d;
            bank_in_q   <= bank_in_d;
            wr_q        <= wr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign bank_we   = bank_we_q;
    assign bank_sel  = bank_sel_q;
    assign bank_in   = bank_in_q;

endmodule

`default_nettype wire
